// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-hazard scoreboard and issue controller for the in-order pipeline.
// Keeps a small pending-write counter per architectural register. Decode is
// held while a source operand has an in-flight write (RAW) or while the
// destination's counter is saturated (structural). Writebacks retire pending
// writes, and a flush clears every counter.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   decode_*          instruction currently held in decode (sources, dest, valid)
//   issue_ready       execute stage can accept an instruction
//   wb_valid, wb_rd   a register write retires this cycle
//   flush             kill all in-flight instructions
//   hazard_stall      decode must hold (RAW or counter full), combinational
//   issue             instruction advances to execute this cycle, combinational
//   pending_mask      registered, bit r set when register r has pending writes
//   stall_cycles      registered, saturating count of hazard-stalled cycles
//   wb_underflow      registered, sticky: writeback to a register with no pending write
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int CNT_WIDTH       = 2,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       decode_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rs2,
    input  logic                       decode_uses_rs1,
    input  logic                       decode_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rd,
    input  logic                       decode_writes_rd,
    input  logic                       issue_ready,
    input  logic                       wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
    input  logic                       flush,
    output logic                       hazard_stall,
    output logic                       issue,
    output logic [NUM_REGS-1:0]        pending_mask,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
    output logic                       wb_underflow
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;

    logic [CNT_WIDTH-1:0] count      [NUM_REGS];
    logic [CNT_WIDTH-1:0] count_next [NUM_REGS];
    logic [NUM_REGS-1:0]  pending_next;

    logic raw1;
    logic raw2;
    logic full;
    logic underflow_now;

    // Hazard detection. x0 is never pending, so it is excluded explicitly
    // rather than relying on its counter staying zero.
    always_comb begin
        raw1 = decode_uses_rs1 && (decode_rs1 != ZERO_REG) && (count[decode_rs1] != '0);
        raw2 = decode_uses_rs2 && (decode_rs2 != ZERO_REG) && (count[decode_rs2] != '0);
        full = decode_writes_rd && (decode_rd != ZERO_REG) && (count[decode_rd] == CNT_MAX);
        underflow_now = wb_valid && (wb_rd != ZERO_REG) && (count[wb_rd] == '0);
    end

    // A stall is reported whenever decode holds a blocked instruction, even if
    // execute is not ready; backpressure alone is not a hazard.
    assign hazard_stall = decode_valid && (raw1 || raw2 || full);
    assign issue        = decode_valid && !hazard_stall && issue_ready && !flush;

    // Next-state counters. The full check above guarantees an increment never
    // wraps, and the decrement is gated on a non-zero count so it never wraps
    // either. An increment and decrement to the same register cancel.
    // NOTE: every variable assigned here gets a value on every path through the
    // block; a missing default would infer a latch.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc_r;
            logic dec_r;
            inc_r = issue && decode_writes_rd && (decode_rd == REG_ADDR_WIDTH'(r)) && (r != 0);
            dec_r = wb_valid && (wb_rd == REG_ADDR_WIDTH'(r)) && (r != 0) && (count[r] != '0);

            if (flush || (r == 0)) begin
                count_next[r] = '0;
            end else if (inc_r && !dec_r) begin
                count_next[r] = count[r] + CNT_WIDTH'(1);
            end else if (dec_r && !inc_r) begin
                count_next[r] = count[r] - CNT_WIDTH'(1);
            end else begin
                count_next[r] = count[r];
            end

            pending_next[r] = (count_next[r] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is a bank of flops, not a RAM, and the
            // hazard logic reads it immediately after reset, so every entry is
            // explicitly cleared.
            for (int r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
            pending_mask <= '0;
            stall_cycles <= '0;
            wb_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count[r] <= count_next[r];
            end
            // Mirrors the post-edge counters so consumers see a clean register.
            pending_mask <= pending_next;

            // Performance counter ignores flush and saturates rather than wrapping.
            if (hazard_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
            end

            // Sticky until reset: a stray writeback means the pipeline and the
            // scoreboard have lost agreement.
            if (underflow_now) begin
                wb_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Cycle-table bench for hazard_scoreboard. Each scenario task queues rows of
// (inputs, expected outputs). While draining, a row's inputs are applied one
// time unit after the rising edge and its expectation is pushed to the
// scoreboard queue; one unit later the expectation is popped and compared.
// hazard_stall and issue reflect the row's own inputs; pending_mask,
// stall_cycles and wb_underflow reflect the edges of the previous rows.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        decode_valid;
    logic [4:0]  decode_rs1;
    logic [4:0]  decode_rs2;
    logic        decode_uses_rs1;
    logic        decode_uses_rs2;
    logic [4:0]  decode_rd;
    logic        decode_writes_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        hazard_stall;
    logic        issue;
    logic [31:0] pending_mask;
    logic [31:0] stall_cycles;
    logic        wb_underflow;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS        (32),
        .REG_ADDR_WIDTH  (5),
        .CNT_WIDTH       (2),
        .STALL_CNT_WIDTH (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .decode_valid     (decode_valid),
        .decode_rs1       (decode_rs1),
        .decode_rs2       (decode_rs2),
        .decode_uses_rs1  (decode_uses_rs1),
        .decode_uses_rs2  (decode_uses_rs2),
        .decode_rd        (decode_rd),
        .decode_writes_rd (decode_writes_rd),
        .issue_ready      (issue_ready),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .flush            (flush),
        .hazard_stall     (hazard_stall),
        .issue            (issue),
        .pending_mask     (pending_mask),
        .stall_cycles     (stall_cycles),
        .wb_underflow     (wb_underflow)
    );

    typedef struct {
        string       name;
        logic        hs;
        logic        iss;
        logic [31:0] mask;
        logic [31:0] stalls;
        logic        uf;
    } exp_t;

    typedef struct {
        logic       dv;
        logic       u1;
        logic [4:0] rs1;
        logic       u2;
        logic [4:0] rs2;
        logic       wr;
        logic [4:0] rd;
        logic       rdy;
        logic       wbv;
        logic [4:0] wbrd;
        logic       fl;
        logic       rst;
        exp_t       e;
    } row_t;

    row_t row_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Queue one cycle of stimulus together with the outputs expected in it.
    task automatic row(input string name,
                       input logic dv, input logic u1, input logic [4:0] rs1,
                       input logic u2, input logic [4:0] rs2,
                       input logic wr, input logic [4:0] rd, input logic rdy,
                       input logic wbv, input logic [4:0] wbrd,
                       input logic fl, input logic rst,
                       input logic hs, input logic iss, input logic [31:0] mask,
                       input logic [31:0] stalls, input logic uf);
        row_t r;
        r.dv = dv;  r.u1 = u1;  r.rs1 = rs1; r.u2 = u2;   r.rs2 = rs2;
        r.wr = wr;  r.rd = rd;  r.rdy = rdy; r.wbv = wbv; r.wbrd = wbrd;
        r.fl = fl;  r.rst = rst;
        r.e.name = name; r.e.hs = hs; r.e.iss = iss; r.e.mask = mask;
        r.e.stalls = stalls; r.e.uf = uf;
        row_q.push_back(r);
    endtask

    // Drive one row's inputs and record its expectation on the scoreboard.
    task automatic apply(input row_t r);
        decode_valid     = r.dv;
        decode_uses_rs1  = r.u1;
        decode_rs1       = r.rs1;
        decode_uses_rs2  = r.u2;
        decode_rs2       = r.rs2;
        decode_writes_rd = r.wr;
        decode_rd        = r.rd;
        issue_ready      = r.rdy;
        wb_valid         = r.wbv;
        wb_rd            = r.wbrd;
        flush            = r.fl;
        reset            = r.rst;
        exp_q.push_back(r.e);
    endtask

    task automatic test_reset();
        row_t c; exp_t e;
        //        name          dv u1 rs1 u2 rs2 wr rd rdy wbv wbrd fl rst  hs iss mask   st uf
        row("reset_hold",       0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 1,   0, 0, 32'h0, 0, 0);
        row("reset_released",   0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0, 0, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // Independent issue, then a producer on x5 and a consumer stalled three cycles.
    task automatic test_raw();
        row_t c; exp_t e;
        row("no_hazard",        1, 1, 3,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 1, 32'h0,  0, 0);
        row("no_hazard_idle",   0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  0, 0);
        row("producer_x5",      1, 0, 0,  0, 0,  1, 5, 1,  0,  0,   0, 0,   0, 1, 32'h0,  0, 0);
        row("raw_stall_1",      1, 1, 5,  0, 0,  0, 0, 1,  0,  0,   0, 0,   1, 0, 32'h20, 0, 0);
        row("raw_stall_2",      1, 1, 5,  0, 0,  0, 0, 1,  0,  0,   0, 0,   1, 0, 32'h20, 1, 0);
        row("raw_stall_3_wb",   1, 1, 5,  0, 0,  0, 0, 1,  1,  5,   0, 0,   1, 0, 32'h20, 2, 0);
        row("raw_release",      1, 1, 5,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 1, 32'h0,  3, 0);
        row("raw_idle",         0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  3, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // Three writers saturate x7; a fourth is held until one retires.
    task automatic test_counter_full();
        row_t c; exp_t e;
        row("w7_first",         1, 0, 0,  0, 0,  1, 7, 1,  0,  0,   0, 0,   0, 1, 32'h0,  3, 0);
        row("w7_second",        1, 0, 0,  0, 0,  1, 7, 1,  0,  0,   0, 0,   0, 1, 32'h80, 3, 0);
        row("w7_third",         1, 0, 0,  0, 0,  1, 7, 1,  0,  0,   0, 0,   0, 1, 32'h80, 3, 0);
        row("w7_full_wb",       1, 0, 0,  0, 0,  1, 7, 1,  1,  7,   0, 0,   1, 0, 32'h80, 3, 0);
        row("w7_after_wb",      1, 0, 0,  0, 0,  1, 7, 1,  0,  0,   0, 0,   0, 1, 32'h80, 4, 0);
        row("w7_full_again",    1, 0, 0,  0, 0,  1, 7, 1,  1,  7,   0, 0,   1, 0, 32'h80, 4, 0);
        row("w7_drain_2",       0, 0, 0,  0, 0,  0, 0, 1,  1,  7,   0, 0,   0, 0, 32'h80, 5, 0);
        row("w7_drain_1",       0, 0, 0,  0, 0,  0, 0, 1,  1,  7,   0, 0,   0, 0, 32'h80, 5, 0);
        row("w7_empty",         0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  5, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // Same-cycle issue and writeback to x9 cancel; x0 is never tracked.
    task automatic test_same_cycle_and_x0();
        row_t c; exp_t e;
        row("w9",               1, 0, 0,  0, 0,  1, 9, 1,  0,  0,   0, 0,   0, 1, 32'h0,   5, 0);
        row("w9_and_wb9",       1, 0, 0,  0, 0,  1, 9, 1,  1,  9,   0, 0,   0, 1, 32'h200, 5, 0);
        row("w9_wb9_again",     0, 0, 0,  0, 0,  0, 0, 1,  1,  9,   0, 0,   0, 0, 32'h200, 5, 0);
        row("w9_cleared",       0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,   5, 0);
        row("write_x0",         1, 0, 0,  0, 0,  1, 0, 1,  0,  0,   0, 0,   0, 1, 32'h0,   5, 0);
        row("read_x0_wb_x0",    1, 1, 0,  1, 0,  0, 0, 1,  1,  0,   0, 0,   0, 1, 32'h0,   5, 0);
        row("x0_after",         0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,   5, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // rs2 hazards, unused-operand masking and issue_ready backpressure.
    task automatic test_operand_select();
        row_t c; exp_t e;
        row("w10",              1, 0, 0,  0, 0,  1, 10, 1, 0,  0,   0, 0,   0, 1, 32'h0,   5, 0);
        row("rs2_raw",          1, 1, 3,  1, 10, 0, 0,  1, 0,  0,   0, 0,   1, 0, 32'h400, 5, 0);
        row("rs1_unused",       1, 0, 10, 1, 3,  0, 0,  1, 0,  0,   0, 0,   0, 1, 32'h400, 6, 0);
        row("not_ready",        1, 1, 3,  0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 32'h400, 6, 0);
        row("not_ready_raw_wb", 1, 1, 10, 0, 0,  0, 0,  0, 1,  10,  0, 0,   1, 0, 32'h400, 6, 0);
        row("operand_idle",     0, 0, 0,  0, 0,  0, 0,  1, 0,  0,   0, 0,   0, 0, 32'h0,   7, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // Flush wins over a same-cycle issue and writeback.
    task automatic test_flush();
        row_t c; exp_t e;
        row("pend_x1",          1, 0, 0,  0, 0,  1, 1, 1,  0,  0,   0, 0,   0, 1, 32'h0,  7, 0);
        row("pend_x2",          1, 0, 0,  0, 0,  1, 2, 1,  0,  0,   0, 0,   0, 1, 32'h2,  7, 0);
        row("pend_x4",          1, 0, 0,  0, 0,  1, 4, 1,  0,  0,   0, 0,   0, 1, 32'h6,  7, 0);
        row("flush_wb_issue",   1, 0, 0,  0, 0,  1, 3, 1,  1,  1,   1, 0,   0, 0, 32'h16, 7, 0);
        row("post_flush",       0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  7, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    // Underflow is sticky through idle and flush, cleared only by reset;
    // then reset overrides a mid-operation stall, writeback and flush.
    task automatic test_underflow_and_reset();
        row_t c; exp_t e;
        row("uf_wb12",          0, 0, 0,  0, 0,  0, 0, 1,  1,  12,  0, 0,   0, 0, 32'h0,  7, 0);
        row("uf_set",           0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  7, 1);
        row("uf_flush",         0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   1, 0,   0, 0, 32'h0,  7, 1);
        row("uf_sticky",        0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  7, 1);
        row("uf_reset",         0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 1,   0, 0, 32'h0,  7, 1);
        row("uf_cleared",       0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  0, 0);
        row("mid_w6",           1, 0, 0,  0, 0,  1, 6, 1,  0,  0,   0, 0,   0, 1, 32'h0,  0, 0);
        row("mid_stall",        1, 1, 6,  0, 0,  0, 0, 1,  0,  0,   0, 0,   1, 0, 32'h40, 0, 0);
        row("mid_reset",        1, 1, 6,  0, 0,  0, 0, 1,  1,  6,   1, 1,   1, 0, 32'h40, 1, 0);
        row("mid_after_reset",  0, 0, 0,  0, 0,  0, 0, 1,  0,  0,   0, 0,   0, 0, 32'h0,  0, 0);
        while (row_q.size() > 0) begin
            c = row_q.pop_front();
            apply(c);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (hazard_stall !== e.hs || issue !== e.iss || pending_mask !== e.mask ||
                stall_cycles !== e.stalls || wb_underflow !== e.uf) begin
                errors++;
                $display("FAIL %s: got hs=%b issue=%b mask=%h stalls=%0d uf=%b, want hs=%b issue=%b mask=%h stalls=%0d uf=%b",
                         e.name, hazard_stall, issue, pending_mask, stall_cycles, wb_underflow,
                         e.hs, e.iss, e.mask, e.stalls, e.uf);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        decode_valid     = 1'b0;
        decode_rs1       = '0;
        decode_rs2       = '0;
        decode_uses_rs1  = 1'b0;
        decode_uses_rs2  = 1'b0;
        decode_rd        = '0;
        decode_writes_rd = 1'b0;
        issue_ready      = 1'b0;
        wb_valid         = 1'b0;
        wb_rd            = '0;
        flush            = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_raw();
        test_counter_full();
        test_same_cycle_and_x0();
        test_operand_select();
        test_flush();
        test_underflow_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard scoreboard and issue controller for the in-order RISC-V pipeline. It sits beside decode and gates decode-to-execute issue. It tracks every architectural register that has an in-flight write and stalls any instruction whose source operands are still pending. It also applies a structural stall when a destination's pending count is full. Writeback retirements clear entries, and a pipeline flush clears the whole scoreboard.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero)
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 2, per-register pending-write counter width (max 2^CNT_WIDTH-1 in-flight writes per register)
- STALL_CNT_WIDTH, 32, width of stall performance counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- decode_valid  in  1  decode holds an instruction this cycle
- decode_rs1  in  REG_ADDR_WIDTH  source register 1 index
- decode_rs2  in  REG_ADDR_WIDTH  source register 2 index
- decode_uses_rs1  in  1  instruction reads rs1
- decode_uses_rs2  in  1  instruction reads rs2
- decode_rd  in  REG_ADDR_WIDTH  destination register index
- decode_writes_rd  in  1  instruction writes rd
- issue_ready  in  1  execute stage can accept an instruction
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  REG_ADDR_WIDTH  retiring destination index
- flush  in  1  kill all in-flight instructions
- hazard_stall  out  1  decode must hold (RAW or counter-full)
- issue  out  1  instruction advances to execute this cycle
- pending_mask  out  NUM_REGS  bit r set when count[r] != 0
- stall_cycles  out  STALL_CNT_WIDTH  saturating count of hazard-stalled cycles
- wb_underflow  out  1  sticky error: writeback to a register with count 0

## Operation
- State: count[r], CNT_WIDTH bits, one per register. count[0] is constant 0.
- raw1 = decode_uses_rs1 & (rs1 != 0) & (count[rs1] != 0). raw2 is the same form for rs2.
- full = decode_writes_rd & (rd != 0) & (count[rd] == all-ones).
- hazard_stall = decode_valid & (raw1 | raw2 | full).
- issue = decode_valid & ~hazard_stall & issue_ready & ~flush.
- inc[r] = issue & decode_writes_rd & (decode_rd == r) & (r != 0).
- dec[r] = wb_valid & (wb_rd == r) & (r != 0) & (count[r] != 0).
- Next count[r] = count[r] + inc[r] - dec[r]. When inc and dec hit the same register, the count is unchanged.
- Writeback to x0 is ignored.
- Writeback with count[wb_rd] == 0 and wb_rd != 0 sets wb_underflow. The flag stays set until reset.
- flush has priority: all counts go to 0 next cycle, and inc/dec are ignored in the flush cycle. Writebacks for flushed instructions never arrive.
- stall_cycles increments each cycle hazard_stall = 1. It saturates at all-ones and is unaffected by flush.
- No same-cycle writeback bypass: a consumer stalled on a register issues no earlier than the cycle after the clearing writeback.

## Timing
- Reset values: all counts 0, pending_mask 0, stall_cycles 0, wb_underflow 0. With decode_valid held at 0, hazard_stall and issue are 0.
- hazard_stall and issue are combinational from the inputs and registered counts, with no added latency.
- Counts, pending_mask, stall_cycles and wb_underflow update on the rising edge. pending_mask is registered, equal to the post-edge counts.
- Producer issues in cycle N: count[rd] = 1 from N+1, so a dependent instruction stalls from N+1.
- Writeback in cycle M with count 1: count = 0 at M+1, and the dependent instruction issues at M+1 if issue_ready.
- Reset mid-operation overrides flush, writeback and issue; all state is cleared the next cycle.
- issue_ready = 0 does not raise hazard_stall and does not increment stall_cycles.

## Test plan
- Reset, then decode_valid=1, rs1=3, uses_rs1 -> hazard_stall=0, issue=1. stall_cycles stays 0.
- Issue rd=5 in cycle 0, then a consumer with rs1=5 -> stalls cycles 1..M. wb_rd=5 at M -> pending_mask[5]=0 and issue=1 at M+1. stall_cycles=M.
- Issue three writes to rd=7 with no writeback -> count[7]=3. A fourth writer to x7 -> hazard_stall=1 (full). One wb_rd=7 -> the fourth writer issues the next cycle.
- Same-cycle issue of rd=9 and wb_rd=9 with count[9]=1 -> count[9] stays 1 and pending_mask[9]=1. Writer to x0 -> never pending. Consumer of x0 -> never stalls.
- Set pending on x1, x2, x4, then assert flush with wb_valid=1, wb_rd=1 -> next cycle pending_mask=0 and wb_underflow=0.
- wb_valid=1, wb_rd=12 with count 0 -> wb_underflow=1 and remains 1 until reset.
